// File: rtl/rgb_lookup_arbiter_if.sv
// Requester, response and memory-side signals of the shared RGB lookup port.
// Latency: none (wiring only).
// Backpressure: reqN_ready qualifies reqN_valid; responses are unthrottled pulses.
interface rgb_lookup_arbiter_if;
    logic        req0_valid;
    logic [2:0]  req0_colour;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_colour;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [23:0] rsp0_rgb;
    logic        rsp1_valid;
    logic [23:0] rsp1_rgb;
    logic        mem_en;
    logic [2:0]  mem_addr;
    logic [23:0] mem_dout;
    logic        busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_colour, req1_valid, req1_colour, mem_dout,
        output req0_ready, req1_ready, rsp0_valid, rsp0_rgb, rsp1_valid, rsp1_rgb,
               mem_en, mem_addr, busy
    );

    // Requesters plus memory side.
    modport master (
        output req0_valid, req0_colour, req1_valid, req1_colour, mem_dout,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_rgb, rsp1_valid, rsp1_rgb,
               mem_en, mem_addr, busy
    );
endinterface

// File: rtl/rgb_lookup_arbiter.sv
// Round-robin share of one 8-entry colour->RGB memory between two requesters.
// Latency: response pulse RD_LATENCY+2 cycles after the accepting handshake.
// Backpressure: one lookup in flight; ready only in IDLE, to the granted requester.
module rgb_lookup_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb_lookup_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    // Final value of the WAIT counter, at which mem_dout is valid.
    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        grant_id;
    logic [1:0]  count;
    logic        mem_en_q;
    logic [2:0]  mem_addr_q;
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic        ready0;
    logic        ready1;
    logic        xfer0;
    logic        xfer1;
    logic        rd_done;

    // Arbitration: a lone valid wins; on a tie the requester not granted last time wins.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst && state == IDLE) begin
            ready0 = bus.req0_valid && (!bus.req1_valid || last_grant);
            ready1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        end
    end

    assign xfer0   = bus.req0_valid && ready0;
    assign xfer1   = bus.req1_valid && ready1;
    assign rd_done = (count == LAST_CNT);

    // Next-state logic for the single-lookup sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer0 || xfer1) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    if (rd_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: launch the memory read on acceptance, count out the latency, capture data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= 3'd0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            count      <= 2'd0;
            rgb0       <= 24'd0;
            rgb1       <= 24'd0;
        end else begin
            // The enable is a single-cycle pulse covering the READ cycle only.
            mem_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer0) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= bus.req0_colour;
                        grant_id   <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (xfer1) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= bus.req1_colour;
                        grant_id   <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                READ: count <= 2'd0;
                WAIT: begin
                    count <= count + 2'd1;
                    if (rd_done) begin
                        if (grant_id) rgb1 <= bus.mem_dout;
                        else          rgb0 <= bus.mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = (state == RESP) && !grant_id;
    assign bus.rsp1_valid = (state == RESP) &&  grant_id;
    assign bus.rsp0_rgb   = rgb0;
    assign bus.rsp1_rgb   = rgb1;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// Directed bench for rgb_lookup_arbiter with RD_LATENCY 1 and 2 instances.
// Expected responses are queued at each accepted handshake and popped on rsp pulses.
// Memory models drive junk outside the single valid data cycle.
module tb_rgb_lookup_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic glitch;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    rgb_lookup_arbiter_if ba();
    rgb_lookup_arbiter_if bb();

    rgb_lookup_arbiter #(.RD_LATENCY(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ba.slave));
    rgb_lookup_arbiter #(.RD_LATENCY(2)) dut_b (.clk(clk), .rst(rst_b), .bus(bb.slave));

    logic [23:0] mem [8] = '{24'h101010, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                             24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hABCDEF};

    typedef struct {
        logic        id;
        logic [23:0] rgb;
        int          t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [23:0] pa;
    logic [23:0] pb1;
    logic [23:0] pb2;

    // Cycle counter used to time handshakes and responses.
    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 memory: data valid only in the cycle after the enable.
    always @(posedge clk) pa <= ba.mem_en ? mem[ba.mem_addr] : 24'hBAD001;

    // Latency-2 memory: two-stage pipe, junk when not enabled.
    always @(posedge clk) begin
        pb1 <= bb.mem_en ? mem[bb.mem_addr] : 24'hBAD002;
        pb2 <= pb1;
    end

    assign ba.mem_dout = pa;
    assign bb.mem_dout = glitch ? 24'h5A5A5A : pb2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a handshake on bus A (sel=0) or B (sel=1); returns cycle and winner.
    task automatic wait_hs(input string tag, input bit sel, output int t, output logic id);
        bit seen;
        seen = 1'b0;
        t = -1;
        id = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (sel ? (bb.req0_valid && bb.req0_ready) : (ba.req0_valid && ba.req0_ready)) begin
                seen = 1'b1; t = cyc; id = 1'b0;
            end else if (sel ? (bb.req1_valid && bb.req1_ready) : (ba.req1_valid && ba.req1_ready)) begin
                seen = 1'b1; t = cyc; id = 1'b1;
            end
        end
        check({tag, " handshake seen"}, 32'(seen), 32'd1);
    endtask

    // Scoreboard for instance A: push on handshake, pop and compare on response.
    always @(negedge clk) begin
        exp_t e;
        if (ba.req0_valid === 1'b1 && ba.req0_ready === 1'b1) qa.push_back('{1'b0, mem[ba.req0_colour], cyc + 3});
        if (ba.req1_valid === 1'b1 && ba.req1_ready === 1'b1) qa.push_back('{1'b1, mem[ba.req1_colour], cyc + 3});
        if (ba.rsp0_valid === 1'b1 || ba.rsp1_valid === 1'b1) begin
            if (qa.size() == 0) begin
                check("A rsp with nothing pending", 32'(qa.size()), 32'd1);
            end else begin
                e = qa.pop_front();
                check("A rsp target", {30'd0, ba.rsp1_valid, ba.rsp0_valid}, e.id ? 32'd2 : 32'd1);
                check("A rsp rgb", {8'd0, e.id ? ba.rsp1_rgb : ba.rsp0_rgb}, {8'd0, e.rgb});
                check("A rsp cycle", 32'(cyc), 32'(e.t));
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (bb.req0_valid === 1'b1 && bb.req0_ready === 1'b1) qb.push_back('{1'b0, mem[bb.req0_colour], cyc + 4});
        if (bb.req1_valid === 1'b1 && bb.req1_ready === 1'b1) qb.push_back('{1'b1, mem[bb.req1_colour], cyc + 4});
        if (bb.rsp0_valid === 1'b1 || bb.rsp1_valid === 1'b1) begin
            if (qb.size() == 0) begin
                check("B rsp with nothing pending", 32'(qb.size()), 32'd1);
            end else begin
                e = qb.pop_front();
                check("B rsp target", {30'd0, bb.rsp1_valid, bb.rsp0_valid}, e.id ? 32'd2 : 32'd1);
                check("B rsp rgb", {8'd0, e.id ? bb.rsp1_rgb : bb.rsp0_rgb}, {8'd0, e.rgb});
                check("B rsp cycle", 32'(cyc), 32'(e.t));
            end
        end
    end

    initial begin
        int   t;
        int   tp;
        logic id;

        // Reset with both valids high.
        rst_a = 1'b1; rst_b = 1'b1; glitch = 1'b0;
        ba.req0_valid = 1'b1; ba.req0_colour = 3'd1; ba.req1_valid = 1'b1; ba.req1_colour = 3'd2;
        bb.req0_valid = 1'b1; bb.req0_colour = 3'd1; bb.req1_valid = 1'b1; bb.req1_colour = 3'd2;
        repeat (3) begin
            @(negedge clk);
            check("rst ready0", 32'(ba.req0_ready), 32'd0);
            check("rst ready1", 32'(ba.req1_ready), 32'd0);
            check("rst mem_en", 32'(ba.mem_en), 32'd0);
            check("rst rsp0_rgb", 32'(ba.rsp0_rgb), 32'd0);
            check("rst rsp1_rgb", 32'(ba.rsp1_rgb), 32'd0);
            check("rst busy", 32'(ba.busy), 32'd0);
            check("rst B ready0", 32'(bb.req0_ready), 32'd0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        ba.req0_valid = 1'b0; ba.req1_valid = 1'b0;
        bb.req0_valid = 1'b0; bb.req1_valid = 1'b0;

        // Single lookup of colour 2 by requester 0.
        step();
        ba.req0_colour = 3'd2; ba.req0_valid = 1'b1;
        wait_hs("single", 1'b0, t, id);
        check("single grant", 32'(id), 32'd0);
        step();
        ba.req0_valid = 1'b0;
        @(negedge clk);
        check("single mem_en T+1", 32'(ba.mem_en), 32'd1);
        check("single mem_addr T+1", 32'(ba.mem_addr), 32'd2);
        check("single busy T+1", 32'(ba.busy), 32'd1);
        @(negedge clk);
        check("single mem_en T+2", 32'(ba.mem_en), 32'd0);
        check("single rsp0 T+2", 32'(ba.rsp0_valid), 32'd0);
        @(negedge clk);
        check("single rsp0 T+3", 32'(ba.rsp0_valid), 32'd1);
        check("single rsp1 T+3", 32'(ba.rsp1_valid), 32'd0);
        check("single rgb T+3", 32'(ba.rsp0_rgb), 32'h00FF00);
        @(negedge clk);
        check("single rsp0 T+4", 32'(ba.rsp0_valid), 32'd0);
        check("single busy T+4", 32'(ba.busy), 32'd0);

        // Lone requester 1: three grants, four cycles apart.
        step();
        ba.req1_colour = 3'd3; ba.req1_valid = 1'b1;
        tp = 0;
        for (int k = 0; k < 3; k++) begin
            wait_hs("lone", 1'b0, t, id);
            check("lone grant", 32'(id), 32'd1);
            if (k > 0) check("lone spacing", 32'(t - tp), 32'd4);
            tp = t;
        end
        step();
        ba.req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("lone rsp1_rgb", 32'(ba.rsp1_rgb), 32'(mem[3]));
        check("lone rsp0_rgb untouched", 32'(ba.rsp0_rgb), 32'h00FF00);

        // Contention: alternate grants starting with requester 0.
        step();
        ba.req0_colour = 3'd1; ba.req0_valid = 1'b1;
        ba.req1_colour = 3'd5; ba.req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_hs("contend", 1'b0, t, id);
            check("contend grant", 32'(id), 32'(k % 2));
            if (k > 0) check("contend spacing", 32'(t - tp), 32'd4);
            tp = t;
        end
        step();
        ba.req0_valid = 1'b0; ba.req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("contend rsp0_rgb", 32'(ba.rsp0_rgb), 32'(mem[1]));
        check("contend rsp1_rgb", 32'(ba.rsp1_rgb), 32'(mem[5]));

        // Latency-2 instance: colour 7, with mem_dout disturbed at T+2.
        step();
        bb.req0_colour = 3'd7; bb.req0_valid = 1'b1;
        wait_hs("lat2", 1'b1, t, id);
        check("lat2 grant", 32'(id), 32'd0);
        step();
        bb.req0_valid = 1'b0;
        step();
        glitch = 1'b1;
        @(negedge clk);
        check("lat2 rsp0 T+2", 32'(bb.rsp0_valid), 32'd0);
        step();
        glitch = 1'b0;
        @(negedge clk);
        check("lat2 rsp0 T+3", 32'(bb.rsp0_valid), 32'd0);
        check("lat2 busy T+3", 32'(bb.busy), 32'd1);
        @(negedge clk);
        check("lat2 rsp0 T+4", 32'(bb.rsp0_valid), 32'd1);
        check("lat2 rgb T+4", 32'(bb.rsp0_rgb), 32'(mem[7]));

        // Reset during WAIT discards the lookup; next tie goes to requester 0.
        step();
        ba.req0_colour = 3'd4; ba.req0_valid = 1'b1;
        wait_hs("rstwait", 1'b0, t, id);
        step();
        ba.req0_valid = 1'b0;
        step();
        rst_a = 1'b1;
        @(negedge clk);
        check("rstwait busy in WAIT", 32'(ba.busy), 32'd1);
        step();
        rst_a = 1'b0;
        qa.delete();
        repeat (4) begin
            @(negedge clk);
            check("rstwait no rsp0", 32'(ba.rsp0_valid), 32'd0);
            check("rstwait idle", 32'(ba.busy), 32'd0);
        end
        check("rstwait rsp0_rgb cleared", 32'(ba.rsp0_rgb), 32'd0);
        step();
        ba.req0_colour = 3'd3; ba.req0_valid = 1'b1;
        ba.req1_colour = 3'd6; ba.req1_valid = 1'b1;
        wait_hs("post-rst tie", 1'b0, t, id);
        check("post-rst tie grant", 32'(id), 32'd0);
        step();
        ba.req0_valid = 1'b0; ba.req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("post-rst rsp0_rgb", 32'(ba.rsp0_rgb), 32'(mem[3]));
        check("post-rst rsp1_rgb", 32'(ba.rsp1_rgb), 32'd0);

        check("A scoreboard drained", 32'(qa.size()), 32'd0);
        check("B scoreboard drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
